// File: rtl/encoder_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder_pio_pkg
// Brief    : Register map and shared constants for the encoder edge-IRQ PIO.
// Revision : 1.0 - initial release
// ============================================================================
package encoder_pio_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAPT = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;
    localparam logic [2:0] ADDR_FILT = 3'd5;
    localparam logic [2:0] ADDR_RAW  = 3'd6;

endpackage : encoder_pio_pkg
`default_nettype wire

// File: rtl/encoder_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : encoder_debounce_ch
// Brief    : One-channel digital debounce with rise/fall update strobes.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_debounce_ch #(
    parameter int FILT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              stable,
    output logic              rise_evt,
    output logic              fall_evt
);

    logic [FILT_W-1:0] cnt;
    logic              differs;
    logic              update;

    assign differs = (sync_in != stable);
    // Compared against the live filt_len so a shortened length fires at once.
    assign update  = differs && (cnt >= filt_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (!differs) begin
            cnt    <= '0;
        end else if (update) begin
            stable <= sync_in;
            cnt    <= '0;
        end else if (cnt != {FILT_W{1'b1}}) begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign rise_evt = update &  sync_in;
    assign fall_evt = update & ~sync_in;

endmodule : encoder_debounce_ch
`default_nettype wire

// File: rtl/encoder_edge_irq_pio.sv
`default_nettype none
// ============================================================================
// Module   : encoder_edge_irq_pio
// Brief    : Avalon-MM PIO with synchroniser, debounce, edge capture and IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_edge_irq_pio
    import encoder_pio_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILT_W      = 8,
    parameter logic [WIDTH-1:0] RISE_RST    = '1,
    parameter logic [WIDTH-1:0] FALL_RST    = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [MAX_WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     raw;
    logic [WIDTH-1:0]     stable;
    logic [WIDTH-1:0]     rise_evt;
    logic [WIDTH-1:0]     fall_evt;
    logic [WIDTH-1:0]     edge_evt;
    logic [WIDTH-1:0]     capt_clr;
    logic [WIDTH-1:0]     rise_en;
    logic [WIDTH-1:0]     fall_en;
    logic [WIDTH-1:0]     irq_mask;
    logic [WIDTH-1:0]     capture;
    logic [FILT_W-1:0]    filt_len;
    logic [MAX_WIDTH-1:0] rd_next;
    logic                 wr;
    logic                 unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        encoder_debounce_ch #(
            .FILT_W   (FILT_W)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .sync_in  (raw[i]),
            .filt_len (filt_len),
            .stable   (stable[i]),
            .rise_evt (rise_evt[i]),
            .fall_evt (fall_evt[i])
        );
    end

    assign edge_evt = (rise_evt & rise_en) | (fall_evt & fall_en);
    assign capt_clr = (wr && (address == ADDR_CAPT)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= RISE_RST;
            fall_en  <= FALL_RST;
            irq_mask <= '0;
            filt_len <= '0;
            capture  <= '0;
        end else begin
            if (wr && (address == ADDR_RISE)) rise_en  <= writedata[WIDTH-1:0];
            if (wr && (address == ADDR_FALL)) fall_en  <= writedata[WIDTH-1:0];
            if (wr && (address == ADDR_MASK)) irq_mask <= writedata[WIDTH-1:0];
            if (wr && (address == ADDR_FILT)) filt_len <= writedata[FILT_W-1:0];
            // A new event on a bit being cleared in the same cycle survives.
            capture <= (capture & ~capt_clr) | edge_evt;
        end
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA: rd_next = MAX_WIDTH'(stable);
            ADDR_RISE: rd_next = MAX_WIDTH'(rise_en);
            ADDR_MASK: rd_next = MAX_WIDTH'(irq_mask);
            ADDR_CAPT: rd_next = MAX_WIDTH'(capture);
            ADDR_FALL: rd_next = MAX_WIDTH'(fall_en);
            ADDR_FILT: rd_next = MAX_WIDTH'(filt_len);
            ADDR_RAW:  rd_next = MAX_WIDTH'(raw);
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign irq = |(capture & irq_mask);

endmodule : encoder_edge_irq_pio
`default_nettype wire

// File: tb/tb_encoder_edge_irq_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_edge_irq_pio
// Brief    : Directed self-checking bench for the encoder edge-IRQ PIO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_edge_irq_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] in_port;
    logic        irq;

    int checks;
    int errors;
    logic [31:0] rd;

    encoder_edge_irq_pio #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .FILT_W      (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All bus tasks start and end on a falling edge.
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wait_cyc(3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        reset_n = 1'b1;
        rd_reg(3'd1, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL reset_rise_en: got %h expected %h", rd, 32'h0000_FFFF);
        end
        rd_reg(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_fall_en: got %h expected %h", rd, 32'h0);
        end
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_filt_len: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_default_edge;
        address = 3'd3;
        in_port = 16'h0001;
        wait_cyc(3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL capt_before_edge3: got %h expected %h", readdata, 32'h0);
        end
        wait_cyc(1);
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL capt_at_edge3: got %h expected %h", readdata, 32'h1);
        end
        rd_reg(3'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL data_bit0: got %h expected %h", rd, 32'h1);
        end
        wr_reg(3'd2, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b expected 1", irq);
        end
        wr_reg(3'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_cleared: got %b expected 0", irq);
        end
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL capt_cleared: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_debounce;
        wr_reg(3'd5, 32'd5);
        in_port = 16'h0005;
        wait_cyc(4);
        in_port = 16'h0001;
        wait_cyc(12);
        rd_reg(3'd0, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL glitch_data: got %h expected %h", rd, 32'h1);
        end
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch_capt: got %h expected %h", rd, 32'h0);
        end
        address = 3'd0;
        in_port = 16'h0005;
        wait_cyc(8);
        checks++;
        if (readdata !== 32'h1) begin
            errors++;
            $display("FAIL filt_before_edge8: got %h expected %h", readdata, 32'h1);
        end
        wait_cyc(1);
        checks++;
        if (readdata !== 32'h5) begin
            errors++;
            $display("FAIL filt_at_edge8: got %h expected %h", readdata, 32'h5);
        end
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL filt_capt: got %h expected %h", rd, 32'h4);
        end
    endtask

    task automatic test_fall_edge;
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd4, 32'h8);
        wr_reg(3'd1, 32'h0);
        wr_reg(3'd3, 32'hFFFF);
        in_port = 16'h0004;
        wait_cyc(6);
        in_port = 16'h000D;
        wait_cyc(6);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL rise_disabled_capt: got %h expected %h", rd, 32'h0);
        end
        rd_reg(3'd0, rd);
        checks++;
        if (rd !== 32'hD) begin
            errors++;
            $display("FAIL rise_disabled_data: got %h expected %h", rd, 32'hD);
        end
        in_port = 16'h0005;
        wait_cyc(6);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL fall_capt: got %h expected %h", rd, 32'h8);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_w1c;
        wr_reg(3'd4, 32'h0);
        wr_reg(3'd1, 32'hF);
        in_port = 16'h0000;
        wait_cyc(6);
        wr_reg(3'd3, 32'hFFFF);
        in_port = 16'h000F;
        wait_cyc(6);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'hF) begin
            errors++;
            $display("FAIL capt_all: got %h expected %h", rd, 32'hF);
        end
        wr_reg(3'd3, 32'h5);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'hA) begin
            errors++;
            $display("FAIL w1c_partial: got %h expected %h", rd, 32'hA);
        end
        in_port = 16'h000D;
        wait_cyc(6);
        in_port = 16'h000F;
        wait_cyc(2);
        wr_reg(3'd3, 32'h2);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'hA) begin
            errors++;
            $display("FAIL set_wins: got %h expected %h", rd, 32'hA);
        end
        wr_reg(3'd3, 32'h2);
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL w1c_bit1: got %h expected %h", rd, 32'h8);
        end
    endtask

    task automatic test_reset_mid_count;
        wr_reg(3'd5, 32'd200);
        wr_reg(3'd2, 32'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_irq: got %b expected 1", irq);
        end
        in_port = 16'h000E;
        wait_cyc(100);
        reset_n = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_irq: got %b expected 0", irq);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        wait_cyc(2);
        reset_n = 1'b1;
        wr_reg(3'd5, 32'd20);
        address = 3'd0;
        wait_cyc(22);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL restart_before: got %h expected %h", readdata, 32'h0);
        end
        wait_cyc(1);
        checks++;
        if (readdata !== 32'hE) begin
            errors++;
            $display("FAIL restart_fire: got %h expected %h", readdata, 32'hE);
        end
        rd_reg(3'd1, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL post_reset_rise_en: got %h expected %h", rd, 32'h0000_FFFF);
        end
        rd_reg(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_mask: got %h expected %h", rd, 32'h0);
        end
        rd_reg(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_fall_en: got %h expected %h", rd, 32'h0);
        end
        rd_reg(3'd3, rd);
        checks++;
        if (rd !== 32'hE) begin
            errors++;
            $display("FAIL post_reset_capt: got %h expected %h", rd, 32'hE);
        end
    endtask

    task automatic test_map_bounds;
        rd_reg(3'd7, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read: got %h expected %h", rd, 32'h0);
        end
        wr_reg(3'd2, 32'hFFFF_FFFF);
        rd_reg(3'd2, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL mask_width: got %h expected %h", rd, 32'h0000_FFFF);
        end
        wr_reg(3'd5, 32'hFFFF_FFFF);
        rd_reg(3'd5, rd);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL filt_width: got %h expected %h", rd, 32'h0000_00FF);
        end
        rd_reg(3'd6, rd);
        checks++;
        if (rd !== 32'h0000_000E) begin
            errors++;
            $display("FAIL raw_read: got %h expected %h", rd, 32'h0000_000E);
        end
        address = 3'd2;
        @(negedge clk);
        address = 3'd7;
        #1;
        checks++;
        if (readdata !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL read_latency_hold: got %h expected %h", readdata, 32'h0000_FFFF);
        end
        @(negedge clk);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL read_latency_one: got %h expected %h", readdata, 32'h0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 16'h0;
        @(negedge clk);
        test_reset();
        test_default_edge();
        test_debounce();
        test_fall_edge();
        test_w1c();
        test_reset_mid_count();
        test_map_bounds();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_encoder_edge_irq_pio
`default_nettype wire
